// File: rtl/saturating_accumulator.sv
// Saturating fixed-point accumulator for the ODE datapath: sums num_terms signed
// operands through a carry_select_adder and hands the result off with valid/ready.

module carry_select_adder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             negative
);
  localparam int BLK  = 4;
  localparam int NBLK = WIDTH / BLK;

  logic [NBLK:0] carry;

  assign carry[0] = cin;

  // Each block precomputes both carry-in outcomes; the incoming carry only selects.
  for (genvar g = 0; g < NBLK; g++) begin : g_blk
    logic [BLK:0] sum0;
    logic [BLK:0] sum1;
    assign sum0 = {1'b0, A[g*BLK +: BLK]} + {1'b0, B[g*BLK +: BLK]};
    assign sum1 = sum0 + (BLK+1)'(1);
    assign result[g*BLK +: BLK] = carry[g] ? sum1[BLK-1:0] : sum0[BLK-1:0];
    assign carry[g+1]           = carry[g] ? sum1[BLK]     : sum0[BLK];
  end

  assign cout     = carry[NBLK];
  assign negative = result[WIDTH-1];
  assign overflow = (A[WIDTH-1] == B[WIDTH-1]) && (result[WIDTH-1] != A[WIDTH-1]);
endmodule

module saturating_accumulator #(
  parameter int WIDTH       = 16,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [COUNT_WIDTH-1:0] num_terms,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_sat,
  input  logic                   out_ready,
  output logic                   busy
);
  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                 state, state_next;
  logic [WIDTH-1:0]       acc, acc_next;
  logic [COUNT_WIDTH-1:0] count, count_next;
  logic                   sat, sat_next;
  logic                   load_out;

  logic [WIDTH-1:0] add_sum;
  logic             add_ovf;
  logic             add_cout_unused;
  logic             add_neg_unused;

  carry_select_adder #(.WIDTH(WIDTH)) u_adder (
    .A        (acc),
    .B        (in_data),
    .cin      (1'b0),
    .result   (add_sum),
    .cout     (add_cout_unused),
    .overflow (add_ovf),
    .negative (add_neg_unused)
  );

  always_comb begin
    state_next = state;
    acc_next   = acc;
    count_next = count;
    sat_next   = sat;
    load_out   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          acc_next   = '0;
          sat_next   = 1'b0;
          count_next = num_terms;
          if (num_terms == '0) begin
            state_next = S_DONE;
            load_out   = 1'b1;
          end else begin
            state_next = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          if (!add_ovf) begin
            acc_next = add_sum;
          end else begin
            // Overflow only happens when both signs agree, so the operand sign picks the rail.
            acc_next = in_data[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                        : {1'b0, {(WIDTH-1){1'b1}}};
            sat_next = 1'b1;
          end
          count_next = count - 1'b1;
          if (count == COUNT_WIDTH'(1)) begin
            state_next = S_DONE;
            load_out   = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Result registers load only on entry to DONE so they keep their value through IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= '0;
      count    <= '0;
      sat      <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      count <= count_next;
      sat   <= sat_next;
      if (load_out) begin
        out_data <= acc_next;
        out_sat  <= sat_next;
      end
    end
  end

  assign in_ready  = (state == S_ACCUM);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
endmodule

// File: tb/tb_saturating_accumulator.sv
// Directed bench for saturating_accumulator: vector table of sums plus
// hand-written reset, stall and start-in-DONE sequences.

module tb_saturating_accumulator;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_terms;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_sat;
  logic        out_ready;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  saturating_accumulator #(.WIDTH(16), .COUNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_terms (num_terms),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       n;
    logic [3:0][15:0] ops;
    logic [15:0]      exp_data;
    logic             exp_sat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input string tag, input logic [7:0] n, input logic [3:0][15:0] ops,
                         input logic [15:0] exp_data, input logic exp_sat);
    start     = 1'b1;
    num_terms = n;
    tick();
    start = 1'b0;
    if (n != 0) check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    for (int i = 0; i < int'(n); i++) begin
      in_valid = 1'b1;
      in_data  = ops[i];
      tick();
    end
    in_valid = 1'b0;
    check({tag, " out_valid"}, 32'(out_valid), 32'd1);
    check({tag, " out_data"},  32'(out_data),  32'(exp_data));
    check({tag, " out_sat"},   32'(out_sat),   32'(exp_sat));
    check({tag, " done_in_ready"}, 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, " idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, " idle_busy"},  32'(busy),      32'd0);
  endtask

  initial begin
    vecs[0] = '{8'd3, {16'h0000, 16'hFFF0, 16'h0020, 16'h0010}, 16'h0020, 1'b0};
    vecs[1] = '{8'd2, {16'h0000, 16'h0000, 16'h2000, 16'h7000}, 16'h7FFF, 1'b1};
    vecs[2] = '{8'd3, {16'h0000, 16'hFFFF, 16'h2000, 16'h7000}, 16'h7FFE, 1'b1};
    vecs[3] = '{8'd2, {16'h0000, 16'h0000, 16'h8001, 16'h8001}, 16'h8000, 1'b1};
    vecs[4] = '{8'd0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, 16'h0000, 1'b0};
    vecs[5] = '{8'd4, {16'h0100, 16'hFFFF, 16'h0001, 16'h1234}, 16'h1334, 1'b0};
    vecs[6] = '{8'd4, {16'h7FFF, 16'h0001, 16'hFFFF, 16'h8000}, 16'h0000, 1'b1};
    vecs[7] = '{8'd1, {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}, 16'h7FFF, 1'b0};

    rst = 1'b1; start = 1'b0; num_terms = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst in_ready",  32'(in_ready),  32'd0);
    check("rst busy",      32'(busy),      32'd0);
    check("rst out_data",  32'(out_data),  32'd0);
    check("rst out_sat",   32'(out_sat),   32'd0);
    rst = 1'b0;
    tick();
    check("idle in_ready", 32'(in_ready), 32'd0);

    for (int v = 0; v < 8; v++)
      run_vec($sformatf("vec%0d", v), vecs[v].n, vecs[v].ops, vecs[v].exp_data, vecs[v].exp_sat);

    // Mid-run reset after 2 of 4 terms, then a fresh sum must start from zero.
    start = 1'b1; num_terms = 8'd4;
    tick();
    start = 1'b0;
    in_valid = 1'b1; in_data = 16'h0100; tick();
    in_data = 16'h0200; tick();
    in_valid = 1'b0;
    check("midrun busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst in_ready",  32'(in_ready),  32'd0);
    check("midrst busy",      32'(busy),      32'd0);
    tick();
    rst = 1'b0;
    tick();
    run_vec("after_rst", 8'd2, {16'h0000, 16'h0000, 16'h0003, 16'h0005}, 16'h0008, 1'b0);

    // Gapped input stream followed by a stalled output and a stray start in DONE.
    start = 1'b1; num_terms = 8'd3;
    tick();
    start = 1'b0;
    in_data = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      tick();
    end
    in_valid = 1'b0;
    check("stall out_valid", 32'(out_valid), 32'd1);
    check("stall out_data",  32'(out_data),  32'h0003);
    for (int i = 0; i < 5; i++) begin
      start     = (i == 2);
      num_terms = 8'd0;
      tick();
      check($sformatf("hold%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d data", i),  32'(out_data),  32'h0003);
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release busy",      32'(busy),      32'd0);
    check("idle keeps data",   32'(out_data),  32'h0003);
    tick();
    check("idle keeps data2",  32'(out_data),  32'h0003);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
